// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - FWFT synchronous FIFO; define SYNC_FIFO_ERR_EN for sticky overflow/underflow flags
module sync_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH_LOG2    = 4,
  parameter int AFULL_THRESH  = (2 ** DEPTH_LOG2) - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic                  in_latch,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out,
  input  logic                  out_latch,
  output logic                  out_valid,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clear_err
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] AF_LEVEL = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE_LEVEL = CW'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] ram [DEPTH];
  logic [CW-1:0]         wr_ptr;
  logic [CW-1:0]         rd_ptr;
  logic                  full;
  logic                  empty;
  logic                  do_wr;
  logic                  do_rd;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign do_wr     = in_latch & ~full;
  assign do_rd     = out_latch & ~empty;

  assign out          = ram[rd_ptr[DEPTH_LOG2-1:0]];
  assign almost_full  = (count >= AF_LEVEL);
  assign almost_empty = (count <= AE_LEVEL);

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      ram[wr_ptr[DEPTH_LOG2-1:0]] <= in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  // Setting wins over clear_err so an error in the clearing cycle is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (in_latch && full) begin
        overflow <= 1'b1;
      end else if (clear_err) begin
        overflow <= 1'b0;
      end
      if (out_latch && empty) begin
        underflow <= 1'b1;
      end else if (clear_err) begin
        underflow <= 1'b0;
      end
    end
  end
`else
  logic unused_clear_err;
  assign unused_clear_err = clear_err;
  assign overflow         = 1'b0;
  assign underflow        = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - self-checking bench for sync_fifo against a queue-based reference
module tb_sync_fifo;

  logic       clk;
  logic       reset;
  logic [7:0] in;
  logic       in_latch;
  logic       in_ready;
  logic [7:0] out;
  logic       out_latch;
  logic       out_valid;
  logic [4:0] count;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;
  logic       clear_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic       exp_ovf = 1'b0;
  logic       exp_unf = 1'b0;

  sync_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .in           (in),
    .in_latch     (in_latch),
    .in_ready     (in_ready),
    .out          (out),
    .out_latch    (out_latch),
    .out_valid    (out_valid),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .clear_err    (clear_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every observable output with the queue model.
  task automatic check_all(input string tag);
    int n;
    n = q.size();
    check({tag, ":count"}, 32'(count), 32'(n));
    check({tag, ":out_valid"}, 32'(out_valid), 32'(n != 0));
    check({tag, ":in_ready"}, 32'(in_ready), 32'(n != 16));
    check({tag, ":almost_full"}, 32'(almost_full), 32'(n >= 14));
    check({tag, ":almost_empty"}, 32'(almost_empty), 32'(n <= 2));
    check({tag, ":overflow"}, 32'(overflow), 32'(exp_ovf));
    check({tag, ":underflow"}, 32'(underflow), 32'(exp_unf));
    if (n != 0) check({tag, ":out"}, 32'(out), 32'(q[0]));
  endtask

  // One clock of stimulus: model the FIFO rules, clock the DUT, compare.
  task automatic step(input string tag, input logic wr, input logic [7:0] d,
                      input logic rd, input logic clr);
    bit was_full, was_empty;
    in = d; in_latch = wr; out_latch = rd; clear_err = clr;
    was_full  = (q.size() == 16);
    was_empty = (q.size() == 0);
`ifdef SYNC_FIFO_ERR_EN
    if (wr && was_full) exp_ovf = 1'b1; else if (clr) exp_ovf = 1'b0;
    if (rd && was_empty) exp_unf = 1'b1; else if (clr) exp_unf = 1'b0;
`endif
    if (rd && !was_empty) void'(q.pop_front());
    if (wr && !was_full) q.push_back(d);
    @(posedge clk);
    #1;
    in_latch = 1'b0; out_latch = 1'b0; clear_err = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [7:0] d;
    logic       w, r, c;

    reset = 1'b1; in = '0; in_latch = 1'b0; out_latch = 1'b0; clear_err = 1'b0;
    #2;
    check_all("reset_t2");
    #10;
    check_all("reset_after_edge");
    reset = 1'b0;

    // Fill with 0x01..0x10, then drain in order.
    for (int i = 1; i <= 16; i++) step("fill16", 1'b1, 8'(i), 1'b0, 1'b0);
    check("full_count", 32'(count), 32'd16);
    check("full_in_ready", 32'(in_ready), 32'd0);
    step("overflow_write", 1'b1, 8'hAA, 1'b0, 1'b0);
    step("overflow_wr_rd", 1'b1, 8'hBB, 1'b1, 1'b0);
    step("refill", 1'b1, 8'hCC, 1'b0, 1'b0);
    step("clear_err", 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      if (i == 0) check("drain_first", 32'(out), 32'h02);
      step("drain16", 1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("drained_valid", 32'(out_valid), 32'd0);

    // Pop on empty together with a write.
    step("underflow_wr", 1'b1, 8'h55, 1'b1, 1'b0);
    check("underflow_out", 32'(out), 32'h55);
    step("pop55", 1'b0, 8'h00, 1'b1, 1'b1);
    step("underflow_only", 1'b0, 8'h00, 1'b1, 1'b0);
    step("clear_and_set", 1'b0, 8'h00, 1'b1, 1'b1);
    step("clear_unf", 1'b0, 8'h00, 1'b0, 1'b1);

    // Steady occupancy of 8 across pointer wrap.
    for (int i = 0; i < 8; i++) step("fill8", 1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step("wrap_wr_rd", 1'b1, 8'($urandom), 1'b1, 1'b0);
    check("wrap_count", 32'(count), 32'd8);

    // Biased random traffic to visit full and empty repeatedly.
    for (int i = 0; i < 400; i++) begin
      if ((i / 50) % 2 == 0) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      c = ($urandom_range(0, 7) == 0);
      d = 8'($urandom);
      step("random", w, d, r, c);
    end

    // Asynchronous reset mid-cycle with 5 entries queued.
    step("pre_reset_clr", 1'b0, 8'h00, 1'b0, 1'b1);
    while (q.size() > 0) step("pre_reset_drain", 1'b0, 8'h00, 1'b1, 1'b1);
    step("pre_reset_clr2", 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step("fill5", 1'b1, 8'($urandom), 1'b0, 1'b0);
    check("pre_reset_count", 32'(count), 32'd5);
    #3;
    reset = 1'b1;
    #1;
    q.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    check_all("async_reset");
    #2;
    reset = 1'b0;
    step("post_reset_wr", 1'b1, 8'h3C, 1'b0, 1'b0);
    step("post_reset_rd", 1'b0, 8'h00, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
